// File: rtl/fir_pkg.sv
// Shared constants for the FIR output chain: sample width, decimation factor and
// accumulator sizing, used by fir_decim_out and the fir_filter integration.
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 8;
  localparam int FIR_DECIM      = 4;
  localparam int FIR_LOG2_DECIM = 2;
  localparam int FIR_FIFO_DEPTH = 4;
  localparam int FIR_FILL_W     = 3;

  // A boxcar sum of 2^l2 samples of dw bits never needs more than dw+l2 bits.
  function automatic int fir_acc_w(input int dw, input int l2);
    return dw + l2;
  endfunction

  localparam int FIR_ACC_W = fir_acc_w(FIR_DATA_WIDTH, FIR_LOG2_DECIM);

endpackage

// File: rtl/fir_sync_fifo.sv
// Parameterised show-ahead FIFO: rdata always presents the head entry; a push
// into a full FIFO is accepted only when a pop frees a slot on the same edge.
module fir_sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int FILL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_pop, do_push;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == FILL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; the head is masked downstream while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    fill_d = fill_q;
    if (do_push && !do_pop) fill_d = fill_q + FILL_W'(1);
    if (do_pop && !do_push) fill_d = fill_q - FILL_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign fill  = fill_q;

endmodule

// File: rtl/fir_decim_out.sv
// Accumulate-and-dump decimator feeding a show-ahead output FIFO with valid/ready.
// Define FIR_DECIM_ROUND_EN to round half up instead of truncating the average.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DECIM      = FIR_DECIM,
  parameter int LOG2_DECIM = FIR_LOG2_DECIM,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH,
  parameter int FILL_W     = FIR_FILL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  overflow,
  output logic [FILL_W-1:0]     fill
);

  localparam int ACC_W = fir_acc_w(DATA_WIDTH, LOG2_DECIM);

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LOG2_DECIM-1:0] phase_q, phase_d;
  logic                  overflow_q;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] head;
  logic                  dump, pop, fifo_full, fifo_empty;

  assign sum  = acc_q + ACC_W'(x_in);
  assign dump = in_valid && (phase_q == LOG2_DECIM'(DECIM - 1));
  assign pop  = y_valid && y_ready;

`ifdef FIR_DECIM_ROUND_EN
  logic [ACC_W:0]        sum_rnd;
  logic [DATA_WIDTH:0]   res_wide;
  assign sum_rnd  = {1'b0, sum} + (ACC_W + 1)'(2 ** (LOG2_DECIM - 1));
  assign res_wide = (DATA_WIDTH + 1)'(sum_rnd >> LOG2_DECIM);
  assign result   = res_wide[DATA_WIDTH] ? '1 : res_wide[DATA_WIDTH-1:0];
`else
  assign result = DATA_WIDTH'(sum >> LOG2_DECIM);
`endif

  // Phase wraps naturally because DECIM is a power of two.
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = phase_q + LOG2_DECIM'(1);
      acc_d   = dump ? '0 : sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      if (dump && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH  (DATA_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .FILL_W (FILL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .pop   (pop),
    .wdata (result),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  assign y_valid  = !fifo_empty;
  assign y_out    = y_valid ? head : '0;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Self-checking bench for fir_decim_out: directed scenarios plus a randomized run
// against a block-average / bounded-queue reference model.
module tb_fir_decim_out;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic       clk, rst, in_valid, y_ready, y_valid, overflow;
  logic [7:0] x_in, y_out;
  logic [2:0] fill;

  int total = 0;
  int bad   = 0;

  int blk_q[$];
  int out_q[$];
  bit m_ovf;

  fir_decim_out #(
    .DATA_WIDTH (8),
    .DECIM      (4),
    .LOG2_DECIM (2),
    .FIFO_DEPTH (4),
    .FILL_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .in_valid (in_valid),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .overflow (overflow),
    .fill     (fill)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int ref_avg(input int s);
`ifdef FIR_DECIM_ROUND_EN
    int r;
    r = (s + DECIM / 2) / DECIM;
    return (r > 255) ? 255 : r;
`else
    return s / DECIM;
`endif
  endfunction

  // Applies one clock of stimulus and advances the reference model for that edge.
  task automatic drive(input bit v, input int x, input bit r);
    bit pop, full, do_push;
    int res;
    in_valid = v;
    x_in     = 8'(x);
    y_ready  = r;
    @(posedge clk);
    pop     = (out_q.size() != 0) && r;
    full    = (out_q.size() == DEPTH);
    do_push = 0;
    res     = 0;
    if (v) begin
      blk_q.push_back(x);
      if (blk_q.size() == DECIM) begin
        res = ref_avg(blk_q.sum());
        blk_q.delete();
        if (!full || pop) do_push = 1;
        else m_ovf = 1;
      end
    end
    if (pop) void'(out_q.pop_front());
    if (do_push) out_q.push_back(res);
    @(negedge clk);
    in_valid = 0;
    y_ready  = 0;
  endtask

  task automatic do_reset();
    in_valid = 0;
    y_ready  = 0;
    rst      = 0;
    @(negedge clk);
    #2 rst = 1;
    blk_q.delete();
    out_q.delete();
    m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 0; y_ready = 0; x_in = 0;
    @(negedge clk);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", y_valid); end
    total++; if (y_out !== 8'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", y_out); end
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
    do_reset();
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_post_valid got=%0b want=0", y_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 7, 0);
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%0b want=1", y_valid); end
    drive(1, 10, 0);
    drive(1, 20, 0);
    rst = 0;
    #1;
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_valid got=%0b want=0", y_valid); end
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL midrst_async_fill got=%0d want=0", fill); end
    #1 rst = 1;
    blk_q.delete(); out_q.delete(); m_ovf = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1, 4, 1);
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%0b want=1", y_valid); end
    total++; if (y_out !== 8'd4) begin bad++; $display("FAIL midrst_y got=%0d want=4", y_out); end
    drive(0, 0, 1);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL midrst_single got=%0b want=0", y_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 10, 1); drive(1, 20, 1); drive(1, 30, 1);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", y_valid); end
    drive(1, 40, 1);
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", y_valid); end
    total++; if (y_out !== 8'd25) begin bad++; $display("FAIL basic_y got=%0d want=25", y_out); end
    drive(0, 0, 1);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL basic_oneshot got=%0b want=0", y_valid); end
  endtask

  task automatic test_rounding();
    int want6;
`ifdef FIR_DECIM_ROUND_EN
    want6 = 2;
`else
    want6 = 1;
`endif
    do_reset();
    drive(1, 1, 1); drive(1, 1, 1); drive(1, 1, 1); drive(1, 2, 1);
    total++; if (y_out !== 8'd1) begin bad++; $display("FAIL round_sum5 got=%0d want=1", y_out); end
    drive(1, 1, 1); drive(1, 1, 1); drive(1, 2, 1); drive(1, 2, 1);
    total++; if (y_out !== 8'(want6)) begin bad++; $display("FAIL round_sum6 got=%0d want=%0d", y_out, want6); end
    for (int i = 0; i < 4; i++) drive(1, 255, 1);
    total++; if (y_out !== 8'd255) begin bad++; $display("FAIL round_max got=%0d want=255", y_out); end
    drive(0, 0, 1);
  endtask

  task automatic test_gapped();
    do_reset();
    drive(1, 8, 1); drive(0, 0, 1); drive(0, 0, 1); drive(1, 8, 1);
    drive(0, 0, 1); drive(1, 8, 1);
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL gap_early got=%0b want=0", y_valid); end
    drive(1, 8, 1);
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%0b want=1", y_valid); end
    total++; if (y_out !== 8'd8) begin bad++; $display("FAIL gap_y got=%0d want=8", y_out); end
    drive(0, 0, 1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 5; k++)
      for (int i = 0; i < 4; i++) drive(1, k, 0);
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL ovf_fill got=%0d want=4", fill); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    drive(0, 0, 0);
    total++; if (y_out !== 8'd1) begin bad++; $display("FAIL ovf_stable got=%0d want=1", y_out); end
    for (int k = 1; k <= 4; k++) begin
      total++; if (y_out !== 8'(k)) begin bad++; $display("FAIL ovf_drain got=%0d want=%0d", y_out, k); end
      drive(0, 0, 1);
    end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b want=0", y_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 1; k <= 4; k++)
      for (int i = 0; i < 4; i++) drive(1, 10 * k, 0);
    drive(1, 50, 0); drive(1, 50, 0); drive(1, 50, 0);
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL fullpop_pre got=%0d want=4", fill); end
    drive(1, 50, 1);
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL fullpop_fill got=%0d want=4", fill); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%0b want=0", overflow); end
    for (int k = 2; k <= 5; k++) begin
      total++; if (y_out !== 8'(10 * k)) begin bad++; $display("FAIL fullpop_order got=%0d want=%0d", y_out, 10 * k); end
      drive(0, 0, 1);
    end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%0b want=0", y_valid); end
  endtask

  task automatic test_random();
    bit v, r;
    int x, want_y;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 255);
      r = (n < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      if (y_valid && r) $display("xfer %0d y_out=%0d fill=%0d", n, y_out, fill);
      drive(v, x, r);
      want_y = (out_q.size() != 0) ? out_q[0] : 0;
      total++; if (y_valid !== (out_q.size() != 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b want=%0b", n, y_valid, out_q.size() != 0); end
      total++; if (y_out !== 8'(want_y)) begin bad++; $display("FAIL rnd_y n=%0d got=%0d want=%0d", n, y_out, want_y); end
      total++; if (fill !== 3'(out_q.size())) begin bad++; $display("FAIL rnd_fill n=%0d got=%0d want=%0d", n, fill, out_q.size()); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%0b want=%0b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_basic();
    test_rounding();
    test_gapped();
    test_overflow();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
